exe_cmd_queue: RTL

- Command buffer and issue stage directly upstream of the execution unit.
- Accepts {operation, argA, argB} commands over a valid/ready handshake and stores them in a DEPTH-entry FIFO.
- Issues at most one command per cycle on registered outputs that drive the execution unit's operation and argument inputs.
- The execution unit registers its result one cycle after its inputs are presented, so this block also produces a result-valid strobe aligned with that registered result.

---
 rtl/exe_cmd_queue.sv | 106 ++++++++++
 1 files changed

// File: rtl/exe_cmd_queue.sv
// Command FIFO and issue register feeding the execution unit.
// Issues the head entry into registered operand outputs and tracks the unit's one-cycle result latency.
module exe_cmd_queue #(
  parameter int m     = 4,
  parameter int n     = 2,
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [n-1:0]             i_oper,
  input  logic [m-1:0]             i_argA,
  input  logic [m-1:0]             i_argB,
  input  logic                     i_stall,
  input  logic                     i_flush,
  output logic [n-1:0]             o_oper,
  output logic [m-1:0]             o_argA,
  output logic [m-1:0]             o_argB,
  output logic                     o_issue,
  output logic                     o_res_valid,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = n + 2 * m;

  logic [EW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [n-1:0]  r_oper;
  logic [m-1:0]  r_argA;
  logic [m-1:0]  r_argB;
  logic          r_issue;
  logic          r_res_valid;

  logic          w_full;
  logic          w_empty;
  logic          w_wr;
  logic          w_rd;
  logic [EW-1:0] w_head;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);
  // No bypass: a slot freed by this cycle's issue is only writable next cycle.
  assign o_ready = !w_full && !i_rst && !i_flush;
  assign w_wr    = i_valid && o_ready;
  assign w_rd    = !w_empty && !i_stall && !i_flush;
  assign w_head  = r_mem[r_rd_ptr];

  // Storage has no reset so it can map onto distributed/block RAM.
  always_ff @(posedge i_clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= {i_oper, i_argA, i_argB};
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_oper      <= '0;
      r_argA      <= '0;
      r_argB      <= '0;
      r_issue     <= 1'b0;
      r_res_valid <= 1'b0;
    end else if (i_flush) begin
      // A command issued last cycle still owns the result emerging now.
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_issue     <= 1'b0;
      r_res_valid <= r_issue;
    end else begin
      r_issue     <= w_rd;
      r_res_valid <= r_issue;
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_rd) begin
        {r_oper, r_argA, r_argB} <= w_head;
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_oper      = r_oper;
  assign o_argA      = r_argA;
  assign o_argB      = r_argB;
  assign o_issue     = r_issue;
  assign o_res_valid = r_res_valid;
  assign o_count     = r_count;
  assign o_full      = w_full;
  assign o_empty     = w_empty;

endmodule
